// File: rtl/ler_mapa_pkg.sv
// Shared geometry, types and cell-index helpers for the attack-map LED matrix scanner.
package ler_mapa_pkg;

   localparam int unsigned NCOLS = 5;
   localparam int unsigned NROWS = 7;
   localparam int unsigned MAP_W = 35;
   localparam int unsigned COL_W = 3;
   localparam int unsigned ROW_W = 3;
   localparam int unsigned IDX_W = 6;

   typedef logic [MAP_W-1:0] map_t;
   typedef logic [NCOLS-1:0] col_sel_t;
   typedef logic [NROWS-1:0] row_drv_t;

   typedef struct packed {
      logic             en;
      logic [ROW_W-1:0] lin;
      logic [COL_W-1:0] col;
   } cursor_t;

   // Cell (r, c) lives at bit r*NCOLS + c of the map.
   function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
      return IDX_W'(r) * IDX_W'(NCOLS) + IDX_W'(c);
   endfunction

   function automatic col_sel_t onehot_col(input logic [COL_W-1:0] c);
      return col_sel_t'(1) << c;
   endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler: tick is high in the cycle the count sits at DIV-1.
module divisor_tick #(
   parameter int unsigned DIV = 10000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ler_mapa.sv
// Column-multiplexed LED-matrix driver for a 7x5 attack map with a blinking cursor overlay.
module ler_mapa
   import ler_mapa_pkg::*;
#(
   parameter int unsigned DIV          = 10000,
   parameter int unsigned BLINK_FRAMES = 25
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [MAP_W-1:0]     mapa,
   input  logic                 cursor_en,
   input  logic [ROW_W-1:0]     cur_lin,
   input  logic [COL_W-1:0]     cur_col,
   output logic [NCOLS-1:0]     coluna,
   output logic [NROWS-1:0]     linha,
   output logic                 frame_done
);

   localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOLS - 1);

   logic tick;

   divisor_tick #(.DIV(DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   logic [COL_W-1:0] col_q,   col_d;
   map_t             buf_q,   buf_d;
   logic [FC_W-1:0]  fcnt_q,  fcnt_d;
   logic             blink_q, blink_d;
   col_sel_t         coluna_d;
   row_drv_t         linha_d;
   logic             fd_d;

   cursor_t          cur;
   logic             wrap;
   logic [COL_W-1:0] new_col;
   map_t             src;
   logic             cur_ok;
   row_drv_t         cells;
   row_drv_t         overlay;

   assign cur     = '{en: cursor_en, lin: cur_lin, col: cur_col};
   assign wrap    = (col_q == COL_LAST);
   assign new_col = wrap ? '0 : col_q + COL_W'(1);
   // The column shown right after the frame boundary must use the freshly sampled map.
   assign src     = wrap ? mapa : buf_q;
   assign cur_ok  = cur.en && (cur.lin < ROW_W'(NROWS)) && (cur.col < COL_W'(NCOLS));

   always_comb begin
      col_d    = col_q;
      buf_d    = buf_q;
      fcnt_d   = fcnt_q;
      blink_d  = blink_q;
      coluna_d = coluna;
      linha_d  = linha;
      fd_d     = 1'b0;
      cells    = '0;
      overlay  = '0;

      if (tick && wrap) begin
         buf_d = mapa;
         fd_d  = 1'b1;
         if (fcnt_q == FC_LAST) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + FC_W'(1);
         end
      end

      for (int r = 0; r < NROWS; r++) begin
         cells[r] = src[cell_idx(ROW_W'(r), new_col)];
      end
      // New blink phase takes effect from column 0 of the new frame.
      if (cur_ok && blink_d && (cur.col == new_col)) begin
         overlay[cur.lin] = 1'b1;
      end

      if (tick) begin
         col_d    = new_col;
         coluna_d = onehot_col(new_col);
         linha_d  = ~(cells ^ overlay);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q      <= '0;
         buf_q      <= '0;
         fcnt_q     <= '0;
         blink_q    <= 1'b0;
         coluna     <= col_sel_t'(1);
         linha      <= '1;
         frame_done <= 1'b0;
      end else begin
         col_q      <= col_d;
         buf_q      <= buf_d;
         fcnt_q     <= fcnt_d;
         blink_q    <= blink_d;
         coluna     <= coluna_d;
         linha      <= linha_d;
         frame_done <= fd_d;
      end
   end

endmodule

// File: tb/tb_ler_mapa.sv
// Directed scoreboard bench for ler_mapa with a short dwell and two-frame blink.
module tb_ler_mapa;

   localparam int unsigned DIV = 4;
   localparam int unsigned BF  = 2;

   logic        clk;
   logic        reset;
   logic [34:0] mapa;
   logic        cursor_en;
   logic [2:0]  cur_lin;
   logic [2:0]  cur_col;
   logic [4:0]  coluna;
   logic [6:0]  linha;
   logic        frame_done;

   ler_mapa #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .reset      (reset),
      .mapa       (mapa),
      .cursor_en  (cursor_en),
      .cur_lin    (cur_lin),
      .cur_col    (cur_col),
      .coluna     (coluna),
      .linha      (linha),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] col;
      logic [6:0] lin;
      logic       fd;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   frame_no = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_lin(input logic [34:0] m, input int c, input bit ph,
                                          input bit cen, input int cl, input int cc);
      logic [6:0] res;
      for (int r = 0; r < 7; r++) begin
         bit ov;
         ov = cen && ph && (r == cl) && (c == cc) && (cl <= 6) && (cc <= 4);
         res[r] = ~(m[r*5+c] ^ ov);
      end
      return res;
   endfunction

   task automatic push(input int c, input logic [6:0] lin, input logic fd);
      exp_t e;
      e.col = 5'(1 << c);
      e.lin = lin;
      e.fd  = fd;
      sb.push_back(e);
   endtask

   // Expectations for one whole frame; phase follows the boundary count since reset.
   task automatic push_frame(input logic [34:0] m, input bit cen, input int cl, input int cc);
      bit ph;
      frame_no++;
      ph = ((frame_no / BF) % 2) == 1;
      for (int c = 0; c < 5; c++) push(c, exp_lin(m, c, ph, cen, cl, cc), c == 0);
   endtask

   // Entered just after a tick edge; each step waits for the next tick edge.
   task automatic run_cols(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk("fd_low", 32'(frame_done), 32'(0));
         repeat (DIV - 1) @(posedge clk);
         #1;
         checks++;
         assert (sb.size() != 0)
         else begin
            failures++;
            $error("FAIL sb_empty observed=0 expected=entry");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("coluna", 32'(coluna), 32'(e.col));
            chk("linha", 32'(linha), 32'(e.lin));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      mapa      = '0;
      cursor_en = 1'b0;
      cur_lin   = 3'd0;
      cur_col   = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_coluna", 32'(coluna), 32'(5'b00001));
      chk("rst_linha", 32'(linha), 32'(7'b1111111));
      chk("rst_fd", 32'(frame_done), 32'(0));

      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_tick_coluna", 32'(coluna), 32'(5'b00001));
      @(posedge clk); #1;
      chk("first_tick_coluna", 32'(coluna), 32'(5'b00010));
      chk("first_tick_linha", 32'(linha), 32'(7'b1111111));

      for (int c = 2; c < 5; c++) push(c, 7'b1111111, 1'b0);
      run_cols(3);

      // Single hit at row 0, column a.
      mapa = 35'd1;
      push_frame(mapa, 1'b0, 0, 0);
      run_cols(5);

      // Map changes mid-frame must not tear.
      push_frame(mapa, 1'b0, 0, 0);
      run_cols(3);
      mapa = '1;
      run_cols(2);
      push_frame(mapa, 1'b0, 0, 0);
      run_cols(5);

      // Cursor on an unhit cell blinks lit.
      mapa      = '0;
      cursor_en = 1'b1;
      cur_lin   = 3'd3;
      cur_col   = 3'd4;
      repeat (4) begin
         push_frame(mapa, 1'b1, 3, 4);
         run_cols(5);
      end

      // Out-of-range cursor column shows nothing.
      cur_col = 3'd5;
      repeat (4) begin
         push_frame(mapa, 1'b1, 3, 5);
         run_cols(5);
      end

      // Cursor on a hit cell blinks dark.
      mapa    = 35'd1 << 19;
      cur_col = 3'd4;
      repeat (4) begin
         push_frame(mapa, 1'b1, 3, 4);
         run_cols(5);
      end

      // Mid-frame reset at column 3.
      push_frame(mapa, 1'b1, 3, 4);
      run_cols(4);
      chk("pre_rst_coluna", 32'(coluna), 32'(5'b01000));
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async_rst_coluna", 32'(coluna), 32'(5'b00001));
      chk("async_rst_linha", 32'(linha), 32'(7'b1111111));
      chk("async_rst_fd", 32'(frame_done), 32'(0));
      cursor_en = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      frame_no = 0;
      for (int c = 1; c < 5; c++) push(c, 7'b1111111, 1'b0);
      run_cols(4);
      push_frame(mapa, 1'b0, 0, 0);
      run_cols(5);

      checks++;
      assert (sb.size() == 0)
      else begin
         failures++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
